// File: rtl/control_seq.sv
// Multi-cycle RV32I control sequencer.
// An explicit FSM (FETCH/EXEC/MEM/TRAP/HALTED) waits on a variable-latency
// memory handshake, traps on memory timeouts and illegal opcodes, and
// supports a debug halt/resume path.  Datapath enables and mux selects are
// decoded combinationally from the current state and the live inputs; only
// the trap cause is held in a register.
module control_seq #(
  parameter int OPCODE_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int HALT_ON_EBREAK = 1,
  parameter int RESET_HALTED   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    is_ebreak,
  input  logic                    branch_taken,
  input  logic                    mem_ready,
  input  logic                    halt_req,
  input  logic                    resume_req,
  output logic                    write_ir,
  output logic                    write_pc,
  output logic                    write_rd,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    addr_sel,
  output logic                    rd_sel,
  output logic [1:0]              alu_insel1,
  output logic [1:0]              alu_insel2,
  output logic [1:0]              pc_sel,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic                    halted,
  output logic [2:0]              state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_TRAP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [2:0] S_RESET = (RESET_HALTED != 0) ? S_HALTED : S_FETCH;

  // RV32I major opcodes, instr[6:2]
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD    = OPCODE_WIDTH'(5'b00000);
  localparam logic [OPCODE_WIDTH-1:0] OP_MISCMEM = OPCODE_WIDTH'(5'b00011);
  localparam logic [OPCODE_WIDTH-1:0] OP_OPIMM   = OPCODE_WIDTH'(5'b00100);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC   = OPCODE_WIDTH'(5'b00101);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE   = OPCODE_WIDTH'(5'b01000);
  localparam logic [OPCODE_WIDTH-1:0] OP_OP      = OPCODE_WIDTH'(5'b01100);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI     = OPCODE_WIDTH'(5'b01101);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH  = OPCODE_WIDTH'(5'b11000);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR    = OPCODE_WIDTH'(5'b11001);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL     = OPCODE_WIDTH'(5'b11011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SYSTEM  = OPCODE_WIDTH'(5'b11100);

  // The wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             is_store;
  logic [2:0]       boundary;
  logic             cause_set;
  logic [1:0]       cause_val;

  assign timeout  = (TIMEOUT_CYCLES != 0) && !mem_ready && (wait_cnt == CNT_MAX);
  assign is_store = (opcode == OP_STORE);
  assign boundary = halt_req ? S_HALTED : S_FETCH;

  // Next-state selection and combinational datapath control decode
  always_comb begin
    state_next = state;
    write_ir   = 1'b0;
    write_pc   = 1'b0;
    write_rd   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    rd_sel     = 1'b0;
    alu_insel1 = 2'b00;
    alu_insel2 = 2'b00;
    pc_sel     = 2'b00;
    trap       = 1'b0;
    halted     = 1'b0;
    cause_set  = 1'b0;
    cause_val  = 2'd0;

    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          write_ir   = 1'b1;
          state_next = S_EXEC;
        end else if (timeout) begin
          cause_set  = 1'b1;
          cause_val  = 2'd1;
          state_next = S_TRAP;
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_LUI: begin
            alu_insel1 = 2'b11;
            alu_insel2 = 2'b01;
            write_rd   = 1'b1;
            write_pc   = 1'b1;
            state_next = boundary;
          end
          OP_AUIPC: begin
            alu_insel1 = 2'b01;
            alu_insel2 = 2'b01;
            write_rd   = 1'b1;
            write_pc   = 1'b1;
            state_next = boundary;
          end
          OP_OPIMM: begin
            alu_insel2 = 2'b01;
            write_rd   = 1'b1;
            write_pc   = 1'b1;
            state_next = boundary;
          end
          OP_OP: begin
            write_rd   = 1'b1;
            write_pc   = 1'b1;
            state_next = boundary;
          end
          OP_JAL, OP_JALR: begin
            alu_insel1 = 2'b01;
            alu_insel2 = 2'b11;
            write_rd   = 1'b1;
            write_pc   = 1'b1;
            pc_sel     = 2'b01;
            state_next = boundary;
          end
          OP_BRANCH: begin
            write_pc   = 1'b1;
            pc_sel     = {1'b0, branch_taken};
            state_next = boundary;
          end
          OP_MISCMEM: begin
            write_pc   = 1'b1;
            state_next = boundary;
          end
          OP_SYSTEM: begin
            if (is_ebreak && (HALT_ON_EBREAK != 0)) begin
              state_next = S_HALTED;
            end else begin
              write_pc   = 1'b1;
              state_next = boundary;
            end
          end
          OP_LOAD: begin
            alu_insel2 = 2'b01;
            mem_read   = 1'b1;
            state_next = S_MEM;
          end
          OP_STORE: begin
            alu_insel2 = 2'b01;
            mem_write  = 1'b1;
            state_next = S_MEM;
          end
          default: begin
            cause_set  = 1'b1;
            cause_val  = 2'd3;
            state_next = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        alu_insel2 = 2'b01;
        mem_write  = is_store;
        mem_read   = !is_store;
        if (mem_ready) begin
          write_pc   = 1'b1;
          write_rd   = !is_store;
          rd_sel     = !is_store;
          state_next = boundary;
        end else if (timeout) begin
          cause_set  = 1'b1;
          cause_val  = 2'd2;
          state_next = S_TRAP;
        end
      end

      S_TRAP: begin
        trap       = 1'b1;
        write_pc   = 1'b1;
        pc_sel     = 2'b10;
        state_next = halt_req ? S_HALTED : S_FETCH;
      end

      S_HALTED: begin
        halted = 1'b1;
        if (resume_req) begin
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter: counts stalled memory cycles, restarts on any progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mem_ready || (state_next != state) ||
                 ((state != S_FETCH) && (state != S_MEM))) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Trap cause register, sticky until the next trap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_cause <= 2'd0;
    end else if (cause_set) begin
      trap_cause <= cause_val;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Testbench for control_seq: a vector table of per-cycle inputs and expected
// outputs, applied through a scoreboard queue, plus looped sequences for the
// timeout corner cases.
module tb_control_seq;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic       is_ebreak;
  logic       branch_taken;
  logic       mem_ready;
  logic       halt_req;
  logic       resume_req;
  logic       write_ir;
  logic       write_pc;
  logic       write_rd;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic       rd_sel;
  logic [1:0] alu_insel1;
  logic [1:0] alu_insel2;
  logic [1:0] pc_sel;
  logic       trap;
  logic [1:0] trap_cause;
  logic       halted;
  logic [2:0] state;

  localparam logic [4:0] LOAD = 5'h00, MISC = 5'h03, OPIMM = 5'h04, AUIPC = 5'h05,
                         STORE = 5'h08, OP = 5'h0C, LUI = 5'h0D, BRANCH = 5'h18,
                         JALR = 5'h19, JAL = 5'h1B, SYS = 5'h1C, BAD = 5'h1F;

  typedef struct {
    string      name;
    logic [4:0] opcode;
    logic       is_ebreak;
    logic       branch_taken;
    logic       mem_ready;
    logic       halt_req;
    logic       resume_req;
    logic       rst_n;
    logic [19:0] expected;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total_checks;
  int   passed_checks;

  control_seq dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_ebreak(is_ebreak),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .halt_req(halt_req),
    .resume_req(resume_req), .write_ir(write_ir), .write_pc(write_pc),
    .write_rd(write_rd), .mem_read(mem_read), .mem_write(mem_write),
    .addr_sel(addr_sel), .rd_sel(rd_sel), .alu_insel1(alu_insel1),
    .alu_insel2(alu_insel2), .pc_sel(pc_sel), .trap(trap),
    .trap_cause(trap_cause), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // Expected-output packing: state, ir, pc, rd, mr, mw, as, rs, a1, a2, ps, trap, cause, halted
  function automatic logic [19:0] mk(int st, int wir, int wpc, int wrd, int mr, int mw,
                                     int as, int rs, int a1, int a2, int ps, int tr,
                                     int tc, int h);
    return {st[2:0], wir[0], wpc[0], wrd[0], mr[0], mw[0], as[0], rs[0],
            a1[1:0], a2[1:0], ps[1:0], tr[0], tc[1:0], h[0]};
  endfunction

  function automatic logic [19:0] fo(int rdy, int tc);
    return mk(0, rdy, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, tc, 0);
  endfunction

  function automatic logic [19:0] ex(int wpc, int wrd, int a1, int a2, int ps, int tc);
    return mk(1, 0, wpc, wrd, 0, 0, 0, 0, a1, a2, ps, 0, tc, 0);
  endfunction

  function automatic logic [19:0] ho(int tc);
    return mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tc, 1);
  endfunction

  function automatic vec_t mkv(string nm, logic [4:0] op, logic eb, logic bt, logic rdy,
                               logic hr, logic rr, logic rn, logic [19:0] e);
    vec_t v;
    v.name = nm; v.opcode = op; v.is_ebreak = eb; v.branch_taken = bt;
    v.mem_ready = rdy; v.halt_req = hr; v.resume_req = rr; v.rst_n = rn;
    v.expected = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    opcode       = v.opcode;
    is_ebreak    = v.is_ebreak;
    branch_taken = v.branch_taken;
    mem_ready    = v.mem_ready;
    halt_req     = v.halt_req;
    resume_req   = v.resume_req;
    rst_n        = v.rst_n;
    sb.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    logic [19:0] act;
    act = {state, write_ir, write_pc, write_rd, mem_read, mem_write, addr_sel, rd_sel,
           alu_insel1, alu_insel2, pc_sel, trap, trap_cause, halted};
    total_checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got outputs %05h, required a queued expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.expected)
        $display("[TB] FAIL %s: got %05h required %05h", e.name, act, e.expected);
      else
        passed_checks++;
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Global bound on simulation time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk = 1'b0;
    total_checks = 0;
    passed_checks = 0;
    opcode = OPIMM; is_ebreak = 0; branch_taken = 0; mem_ready = 0;
    halt_req = 0; resume_req = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mkv("reset_fetch",   OPIMM,  0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_opimm",    OPIMM,  0,0,1,0,0,1, ex(1,1,0,1,0,0)));
    tbl.push_back(mkv("fetch_lui",     LUI,    0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_lui",      LUI,    0,0,1,0,0,1, ex(1,1,3,1,0,0)));
    tbl.push_back(mkv("fetch_auipc",   AUIPC,  0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_auipc",    AUIPC,  0,0,1,0,0,1, ex(1,1,1,1,0,0)));
    tbl.push_back(mkv("fetch_op",      OP,     0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_op",       OP,     0,0,1,0,0,1, ex(1,1,0,0,0,0)));
    tbl.push_back(mkv("fetch_jal",     JAL,    0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_jal",      JAL,    0,0,1,0,0,1, ex(1,1,1,3,1,0)));
    tbl.push_back(mkv("fetch_jalr",    JALR,   0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_jalr",     JALR,   0,0,1,0,0,1, ex(1,1,1,3,1,0)));
    tbl.push_back(mkv("fetch_br1",     BRANCH, 0,1,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_br_taken", BRANCH, 0,1,1,0,0,1, ex(1,0,0,0,1,0)));
    tbl.push_back(mkv("fetch_br0",     BRANCH, 0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_br_not",   BRANCH, 0,0,1,0,0,1, ex(1,0,0,0,0,0)));
    tbl.push_back(mkv("fetch_misc",    MISC,   0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_misc",     MISC,   0,0,1,0,0,1, ex(1,0,0,0,0,0)));
    tbl.push_back(mkv("fetch_sys",     SYS,    0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_sys",      SYS,    0,0,1,0,0,1, ex(1,0,0,0,0,0)));
    tbl.push_back(mkv("fetch_load",    LOAD,   0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_load",     LOAD,   0,0,0,0,0,1, mk(1,0,0,0,1,0,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_load_w1",   LOAD,   0,0,0,0,0,1, mk(2,0,0,0,1,0,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_load_w2",   LOAD,   0,0,0,0,0,1, mk(2,0,0,0,1,0,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_load_w3",   LOAD,   0,0,0,0,0,1, mk(2,0,0,0,1,0,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_load_rdy",  LOAD,   0,0,1,0,0,1, mk(2,0,1,1,1,0,0,1,0,1,0,0,0,0)));
    tbl.push_back(mkv("fetch_st_wait", STORE,  0,0,0,0,0,1, fo(0,0)));
    tbl.push_back(mkv("fetch_st_rdy",  STORE,  0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_store",    STORE,  0,0,0,0,0,1, mk(1,0,0,0,0,1,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_st_halt_w", STORE,  0,0,0,1,0,1, mk(2,0,0,0,0,1,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("mem_st_halt_r", STORE,  0,0,1,1,0,1, mk(2,0,1,0,0,1,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv("halted_ignore", OPIMM,  0,0,1,1,0,1, ho(0)));
    tbl.push_back(mkv("halted_resume", OPIMM,  0,0,1,1,1,1, ho(0)));
    tbl.push_back(mkv("fetch_bad",     BAD,    0,0,1,0,0,1, fo(1,0)));
    tbl.push_back(mkv("exec_bad",      BAD,    0,0,1,0,0,1, ex(0,0,0,0,0,0)));
    tbl.push_back(mkv("trap_illegal",  BAD,    0,0,1,0,0,1, mk(3,0,1,0,0,0,0,0,0,0,2,1,3,0)));
    tbl.push_back(mkv("fetch_ebreak",  SYS,    1,0,1,0,0,1, fo(1,3)));
    tbl.push_back(mkv("exec_ebreak",   SYS,    1,0,1,0,0,1, ex(0,0,0,0,0,3)));
    tbl.push_back(mkv("halted_ebreak", SYS,    1,0,1,0,1,1, ho(3)));
    tbl.push_back(mkv("fetch_st2",     STORE,  0,0,1,0,0,1, fo(1,3)));
    tbl.push_back(mkv("exec_st2",      STORE,  0,0,0,0,0,1, mk(1,0,0,0,0,1,0,0,0,1,0,0,3,0)));
    tbl.push_back(mkv("mem_st_reset",  STORE,  0,0,0,0,0,0, mk(2,0,0,0,0,1,0,0,0,1,0,0,3,0)));
    tbl.push_back(mkv("post_reset",    OPIMM,  0,0,0,0,0,1, fo(0,0)));

    foreach (tbl[i]) step(tbl[i]);

    // Fetch timeout: post_reset was stall cycle 1 of 16; the 16th stalls out
    for (int i = 0; i < 15; i++)
      step(mkv("fetch_stall", OPIMM, 0,0,0,0,0,1, fo(0,0)));
    step(mkv("trap_fetch_to", OPIMM, 0,0,0,1,0,1, mk(3,0,1,0,0,0,0,0,0,0,2,1,1,0)));
    step(mkv("halted_after_trap", OPIMM, 0,0,0,0,1,1, ho(1)));

    // Load/store timeout in MEM
    step(mkv("fetch_load2", LOAD, 0,0,1,0,0,1, fo(1,1)));
    step(mkv("exec_load2",  LOAD, 0,0,0,0,0,1, mk(1,0,0,0,1,0,0,0,0,1,0,0,1,0)));
    for (int i = 0; i < 16; i++)
      step(mkv("mem_stall", LOAD, 0,0,0,0,0,1, mk(2,0,0,0,1,0,0,0,0,1,0,0,1,0)));
    step(mkv("trap_mem_to", LOAD, 0,0,0,0,0,1, mk(3,0,1,0,0,0,0,0,0,0,2,1,2,0)));

    // Ready on the last permitted stall cycle wins over the timeout
    for (int i = 0; i < 15; i++)
      step(mkv("fetch_stall2", OPIMM, 0,0,0,0,0,1, fo(0,2)));
    step(mkv("fetch_ready_wins", OPIMM, 0,0,1,0,0,1, fo(1,2)));
    step(mkv("exec_halt_bound",  OPIMM, 0,0,0,1,0,1, ex(1,1,0,1,0,2)));
    step(mkv("halted_boundary",  OPIMM, 0,0,0,0,0,1, ho(2)));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
